layer1_neuron_mac: RTL and testbench



---
 rtl/nn_pkg.sv | 33 +++
 rtl/layer1_neuron_mac_mac16.sv | 40 ++++
 rtl/layer1_neuron_mac.sv | 161 ++++++++++++++++
 tb/tb_layer1_neuron_mac.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared neural-net constants and types used by the copy stage and the layer-1 neuron.
// Also holds the ReLU / rescale / saturate output function.
package nn_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_RD_X = 4'd1,
        ST_WT_X = 4'd2,
        ST_RD_W = 4'd3,
        ST_WT_W = 4'd4,
        ST_MAC  = 4'd5,
        ST_WR   = 4'd6,
        ST_DONE = 4'd7
    } state_t;

    localparam int          N_DEFAULT        = 784;
    localparam logic [31:0] X_BASE_DEFAULT   = 32'd650_000;
    localparam logic [31:0] W_BASE_DEFAULT   = 32'd700_000;
    localparam logic [31:0] OUT_BASE_DEFAULT = 32'd750_000;
    localparam int          ACC_W            = 40;

    // Negative sums clamp to zero; positive sums drop the fraction bits and clamp to int16 max.
    function automatic logic [15:0] relu_sat(input logic signed [ACC_W-1:0] acc, input int frac);
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> frac;
        if (acc < 0)
            return 16'h0000;
        if (shifted > 40'sh00_0000_7FFF)
            return 16'h7FFF;
        return 16'(shifted);
    endfunction

endpackage

// File: rtl/layer1_neuron_mac_mac16.sv
// Signed 16x16 multiply-accumulate into a 40-bit accumulator.
// result_next shows the output word as it will be once the current product is added.
module mac16
    import nn_pkg::*;
#(
    parameter int FRAC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result_next
);

    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    always_comb begin
        prod        = $signed(a) * $signed(b);
        acc_sum     = acc_q + {{(ACC_W-32){prod[31]}}, prod};
        result_next = relu_sat(acc_sum, FRAC);
        acc_d       = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = acc_sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

endmodule

// File: rtl/layer1_neuron_mac.sv
// Layer-1 neuron: streams N inputs and N weights from SDRAM, accumulates, applies ReLU/saturation
// and writes one 16-bit result back, then handshakes completion with ready/done.
module layer1_neuron_mac
    import nn_pkg::*;
#(
    parameter int          N         = N_DEFAULT,
    parameter logic [31:0] X_BASE    = X_BASE_DEFAULT,
    parameter logic [31:0] W_BASE    = W_BASE_DEFAULT,
    parameter logic [31:0] OUT_BASE  = OUT_BASE_DEFAULT,
    parameter logic [31:0] ADDR_STEP = 32'd2,
    parameter int          FRAC      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [15:0] readdata,
    output logic        chipselect,
    output logic [1:0]  byteenable,
    output logic        read_n,
    output logic        write_n,
    output logic [31:0] address,
    output logic [15:0] writedata,
    input  logic        ready,
    output logic        done,
    output logic [31:0] toHexLed
);

    localparam logic [31:0] N_U = 32'(N);

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [15:0] x_q, x_d;
    logic [15:0] w_q, w_d;
    logic        read_n_q, read_n_d;
    logic        write_n_q, write_n_d;
    logic [31:0] address_q, address_d;
    logic [15:0] writedata_q, writedata_d;
    logic        done_q, done_d;
    logic [15:0] result_next;

    mac16 #(.FRAC(FRAC)) u_mac (
        .clk         (clk),
        .reset       (reset),
        .clr         (state_q == ST_IDLE),
        .en          (state_q == ST_MAC),
        .a           (x_q),
        .b           (w_q),
        .result_next (result_next)
    );

    // Each request is raised on the transition into its state so read_n/write_n/address are registered.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        x_d         = x_q;
        w_d         = w_q;
        read_n_d    = read_n_q;
        write_n_d   = write_n_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        done_d      = done_q;
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (ready) begin
                    state_d   = ST_RD_X;
                    read_n_d  = 1'b0;
                    address_d = X_BASE;
                end
            end
            ST_RD_X: begin
                if (!waitrequest) begin
                    read_n_d = 1'b1;
                    state_d  = ST_WT_X;
                end
            end
            ST_WT_X: begin
                if (readdatavalid) begin
                    x_d       = readdata;
                    state_d   = ST_RD_W;
                    read_n_d  = 1'b0;
                    address_d = W_BASE + count_q * ADDR_STEP;
                end
            end
            ST_RD_W: begin
                if (!waitrequest) begin
                    read_n_d = 1'b1;
                    state_d  = ST_WT_W;
                end
            end
            ST_WT_W: begin
                if (readdatavalid) begin
                    w_d     = readdata;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                count_d = count_q + 32'd1;
                if (count_d < N_U) begin
                    state_d   = ST_RD_X;
                    read_n_d  = 1'b0;
                    address_d = X_BASE + count_d * ADDR_STEP;
                end else begin
                    state_d     = ST_WR;
                    write_n_d   = 1'b0;
                    address_d   = OUT_BASE;
                    writedata_d = result_next;
                end
            end
            ST_WR: begin
                if (!waitrequest) begin
                    write_n_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!ready) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            x_q         <= '0;
            w_q         <= '0;
            read_n_q    <= 1'b1;
            write_n_q   <= 1'b1;
            address_q   <= '0;
            writedata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            x_q         <= x_d;
            w_q         <= w_d;
            read_n_q    <= read_n_d;
            write_n_q   <= write_n_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            done_q      <= done_d;
        end
    end

    assign chipselect = 1'b1;
    assign byteenable = 2'b11;
    assign read_n     = read_n_q;
    assign write_n    = write_n_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign done       = done_q;
    assign toHexLed   = {count_q[15:0], writedata_q[11:0], state_q};

endmodule

// File: tb/tb_layer1_neuron_mac.sv
// Bench for layer1_neuron_mac: an SDRAM slave model with configurable stalls and read latency
// serves input/weight vectors; results are compared to a plain-arithmetic dot-product model.
module tb_layer1_neuron_mac;

    localparam int          NUM  = 784;
    localparam logic [31:0] XB   = 32'd650_000;
    localparam logic [31:0] WB   = 32'd700_000;
    localparam logic [31:0] OB   = 32'd750_000;
    localparam int          BUDGET = 60000;

    logic        clk = 1'b0;
    logic        reset;
    logic        waitrequest;
    logic        readdatavalid;
    logic [15:0] readdata;
    logic        ready;
    logic        chipselect;
    logic [1:0]  byteenable;
    logic        read_n;
    logic        write_n;
    logic [31:0] address;
    logic [15:0] writedata;
    logic        done;
    logic [31:0] to_hex_led;

    int total = 0;
    int bad   = 0;

    logic [15:0] xv [NUM];
    logic [15:0] wv [NUM];

    int          stall_cfg = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          spur_req = 1'b0;
    bit          in_req = 1'b0;
    int          stall_left = 0;
    logic [31:0] hold_addr = '0;
    bit          hold_rd = 1'b0;
    bit          hold_wr = 1'b0;
    bit          rd_pending = 1'b0;
    int          rd_delay = 0;
    logic [15:0] rd_data = '0;
    int          viol_stable = 0;
    int          viol_outst = 0;
    int          bad_addr = 0;
    int          req_seen = 0;
    int          x_reads = 0;
    logic [31:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];

    layer1_neuron_mac dut (
        .clk           (clk),
        .reset         (reset),
        .waitrequest   (waitrequest),
        .readdatavalid (readdatavalid),
        .readdata      (readdata),
        .chipselect    (chipselect),
        .byteenable    (byteenable),
        .read_n        (read_n),
        .write_n       (write_n),
        .address       (address),
        .writedata     (writedata),
        .ready         (ready),
        .done          (done),
        .toHexLed      (to_hex_led)
    );

    always #5 clk = ~clk;

    // SDRAM slave: decides waitrequest/readdatavalid on the falling edge and logs protocol violations.
    initial begin
        waitrequest   = 1'b0;
        readdatavalid = 1'b0;
        readdata      = '0;
        forever begin
            @(negedge clk);
            readdatavalid = 1'b0;
            if (rd_pending) begin
                rd_delay--;
                if (rd_delay <= 0) begin
                    readdatavalid = 1'b1;
                    readdata      = rd_data;
                    rd_pending    = 1'b0;
                end
            end
            if (spur_req) begin
                readdatavalid = 1'b1;
                readdata      = 16'h5A5A;
                spur_req      = 1'b0;
            end
            if (reset === 1'b1) begin
                in_req      = 1'b0;
                waitrequest = 1'b0;
            end else if (read_n === 1'b0 || write_n === 1'b0) begin
                if (read_n === 1'b0 && write_n === 1'b0)
                    viol_stable++;
                if (!in_req) begin
                    in_req     = 1'b1;
                    stall_left = stall_cfg;
                    hold_addr  = address;
                    hold_rd    = (read_n === 1'b0);
                    hold_wr    = (write_n === 1'b0);
                    req_seen++;
                end else if (address !== hold_addr || (read_n === 1'b0) != hold_rd
                             || (write_n === 1'b0) != hold_wr) begin
                    viol_stable++;
                end
                if (stall_left > 0) begin
                    waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    waitrequest = 1'b0;
                    in_req      = 1'b0;
                    if (hold_rd) begin
                        if (rd_pending)
                            viol_outst++;
                        rd_pending = 1'b1;
                        rd_delay   = $urandom_range(lat_hi, lat_lo);
                        if (hold_addr >= XB && hold_addr < XB + 2 * NUM && hold_addr[0] == 1'b0) begin
                            rd_data = xv[(hold_addr - XB) / 2];
                            x_reads++;
                        end else if (hold_addr >= WB && hold_addr < WB + 2 * NUM && hold_addr[0] == 1'b0) begin
                            rd_data = wv[(hold_addr - WB) / 2];
                        end else begin
                            rd_data = 16'hDEAD;
                            bad_addr++;
                        end
                    end else begin
                        wr_addr_q.push_back(hold_addr);
                        wr_data_q.push_back(writedata);
                    end
                end
            end else begin
                if (in_req)
                    viol_stable++;
                in_req      = 1'b0;
                waitrequest = 1'b0;
            end
        end
    end

    // Reference: signed dot product, ReLU, drop 8 fraction bits, clamp to int16 max.
    function automatic logic [15:0] model_result();
        longint sum = 0;
        for (int i = 0; i < NUM; i++)
            sum += longint'(shortint'(xv[i])) * longint'(shortint'(wv[i]));
        if (sum < 0)
            return 16'h0000;
        sum = sum / 256;
        if (sum > 32767)
            return 16'h7FFF;
        return 16'(sum);
    endfunction

    task automatic fill_const(input logic [15:0] xval, input logic [15:0] wval);
        for (int i = 0; i < NUM; i++) begin
            xv[i] = xval;
            wv[i] = wval;
        end
    endtask

    task automatic clear_viol();
        viol_stable = 0;
        viol_outst  = 0;
        bad_addr    = 0;
    endtask

    // Raises ready and waits (bounded) for done; optionally drops ready a few cycles into the run.
    task automatic do_run(input bit hold_ready, output int cycles, output bit timed_out);
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        ready     = 1'b1;
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk);
            cycles++;
            #1;
            if (!hold_ready && cycles == 3)
                ready = 1'b0;
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (read_n !== 1'b1) begin bad++; $display("FAIL reset_read_n got=%b want=1", read_n); end
        total++; if (write_n !== 1'b1) begin bad++; $display("FAIL reset_write_n got=%b want=1", write_n); end
        total++; if (address !== 32'd0) begin bad++; $display("FAIL reset_address got=%0d want=0", address); end
        total++; if (writedata !== 16'd0) begin bad++; $display("FAIL reset_writedata got=%h want=0000", writedata); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (chipselect !== 1'b1 || byteenable !== 2'b11) begin bad++; $display("FAIL reset_cs_be got=%b/%b want=1/11", chipselect, byteenable); end
        total++; if (to_hex_led[31:4] !== 28'd0) begin bad++; $display("FAIL reset_hexled got=%h want=0000000x", to_hex_led); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (read_n !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL idle_quiet got read_n=%b done=%b want 1/0", read_n, done); end
    endtask

    task automatic test_basic();
        int cycles;
        bit to;
        fill_const(16'h0010, 16'h0010);
        stall_cfg = 0; lat_lo = 1; lat_hi = 1;
        clear_viol();
        do_run(1'b1, cycles, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
        total++; if (cycles !== NUM * 5 + 2) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", cycles, NUM * 5 + 2); end
        total++; if (wr_addr_q.size() !== 1) begin bad++; $display("FAIL basic_writes got=%0d want=1", wr_addr_q.size()); end
        total++; if (wr_addr_q.size() > 0 && wr_addr_q[0] !== OB) begin bad++; $display("FAIL basic_wr_addr got=%0d want=%0d", wr_addr_q[0], OB); end
        total++; if (wr_data_q.size() > 0 && wr_data_q[0] !== 16'h0310) begin bad++; $display("FAIL basic_wr_data got=%h want=0310", wr_data_q[0]); end
        total++; if (bad_addr !== 0) begin bad++; $display("FAIL basic_rd_addr got=%0d bad want=0", bad_addr); end
        ready = 1'b0;
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_fall got=%b want=0", done); end
    endtask

    task automatic test_saturate();
        int cycles;
        bit to;
        fill_const(16'h0100, 16'h0100);
        do_run(1'b0, cycles, to);
        total++; if (to) begin bad++; $display("FAIL sat_timeout got=no_done want=done"); end
        total++; if (wr_data_q.size() !== 1 || wr_data_q[0] !== 16'h7FFF) begin bad++; $display("FAIL sat_wr_data got=%h (n=%0d) want=7fff", writedata, wr_data_q.size()); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL sat_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_negative();
        int cycles;
        bit to;
        fill_const(16'h0010, 16'hFFF0);
        do_run(1'b0, cycles, to);
        total++; if (to) begin bad++; $display("FAIL neg_timeout got=no_done want=done"); end
        total++; if (wr_data_q.size() !== 1 || wr_data_q[0] !== 16'h0000) begin bad++; $display("FAIL neg_wr_data got=%h (n=%0d) want=0000", writedata, wr_data_q.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int cycles;
        bit to;
        fill_const(16'h0010, 16'h0010);
        stall_cfg = 3; lat_lo = 1; lat_hi = 5;
        clear_viol();
        do_run(1'b0, cycles, to);
        total++; if (to) begin bad++; $display("FAIL stall_timeout got=no_done want=done"); end
        total++; if (wr_data_q.size() !== 1 || wr_data_q[0] !== 16'h0310) begin bad++; $display("FAIL stall_wr_data got=%h (n=%0d) want=0310", writedata, wr_data_q.size()); end
        total++; if (wr_addr_q.size() > 0 && wr_addr_q[0] !== OB) begin bad++; $display("FAIL stall_wr_addr got=%0d want=%0d", wr_addr_q[0], OB); end
        total++; if (viol_stable !== 0) begin bad++; $display("FAIL stall_stability got=%0d violations want=0", viol_stable); end
        total++; if (viol_outst !== 0) begin bad++; $display("FAIL stall_outstanding got=%0d violations want=0", viol_outst); end
        total++; if (bad_addr !== 0) begin bad++; $display("FAIL stall_rd_addr got=%0d bad want=0", bad_addr); end
        stall_cfg = 0; lat_lo = 1; lat_hi = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int cycles;
        bit to;
        logic [15:0] expected;
        for (int i = 0; i < NUM; i++) begin
            xv[i] = 16'($urandom_range(255, 0));
            wv[i] = 16'(int'($urandom_range(255, 0)) - 64);
        end
        expected = model_result();
        lat_lo = 1; lat_hi = 3;
        clear_viol();
        do_run(1'b0, cycles, to);
        total++; if (to) begin bad++; $display("FAIL rand_timeout got=no_done want=done"); end
        total++; if (wr_data_q.size() !== 1 || wr_data_q[0] !== expected) begin bad++; $display("FAIL rand_wr_data got=%h (n=%0d) want=%h", writedata, wr_data_q.size(), expected); end
        total++; if (viol_outst !== 0) begin bad++; $display("FAIL rand_outstanding got=%0d want=0", viol_outst); end
        lat_lo = 1; lat_hi = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midrun();
        int cycles;
        bit to;
        bit reached;
        fill_const(16'h0010, 16'h0010);
        lat_lo = 2; lat_hi = 4;
        @(negedge clk);
        x_reads = 0;
        ready   = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (x_reads >= 101) begin
                reached = 1'b1;
                break;
            end
        end
        total++; if (!reached) begin bad++; $display("FAIL rst_reach_count got=%0d xreads want=101", x_reads); end
        #2;
        reset = 1'b1;
        ready = 1'b0;
        @(posedge clk);
        #1;
        total++; if (read_n !== 1'b1 || address !== 32'd0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_values got read_n=%b addr=%0d done=%b want 1/0/0", read_n, address, done); end
        total++; if (to_hex_led[31:4] !== 28'd0) begin bad++; $display("FAIL rst_mid_hexled got=%h want=0000000x", to_hex_led); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        spur_req = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        total++; if (read_n !== 1'b1 || to_hex_led[31:4] !== 28'd0) begin bad++; $display("FAIL rst_idle_spurious got read_n=%b hexled=%h want 1/0000000x", read_n, to_hex_led); end
        clear_viol();
        do_run(1'b0, cycles, to);
        total++; if (to) begin bad++; $display("FAIL rst_rerun_timeout got=no_done want=done"); end
        total++; if (wr_data_q.size() !== 1 || wr_data_q[0] !== 16'h0310) begin bad++; $display("FAIL rst_rerun_data got=%h (n=%0d) want=0310", writedata, wr_data_q.size()); end
        lat_lo = 1; lat_hi = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ready_hold();
        int cycles;
        bit to;
        int req_before;
        int done_low;
        fill_const(16'h0010, 16'h0010);
        do_run(1'b1, cycles, to);
        total++; if (to) begin bad++; $display("FAIL hold_timeout got=no_done want=done"); end
        req_before = req_seen;
        done_low   = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1)
                done_low++;
        end
        total++; if (done_low !== 0) begin bad++; $display("FAIL hold_done_stays got=%0d low cycles want=0", done_low); end
        total++; if (req_seen !== req_before) begin bad++; $display("FAIL hold_no_traffic got=%0d requests want=0", req_seen - req_before); end
        ready = 1'b0;
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL hold_done_fall got=%b want=0", done); end
        do_run(1'b1, cycles, to);
        total++; if (to) begin bad++; $display("FAIL back_to_back_timeout got=no_done want=done"); end
        total++; if (wr_data_q.size() !== 1 || wr_data_q[0] !== 16'h0310) begin bad++; $display("FAIL back_to_back_data got=%h (n=%0d) want=0310", writedata, wr_data_q.size()); end
        total++; if (cycles !== NUM * 5 + 2) begin bad++; $display("FAIL back_to_back_latency got=%0d want=%0d", cycles, NUM * 5 + 2); end
        ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ready = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_negative();
        test_stall();
        test_random();
        test_reset_midrun();
        test_ready_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
